alu_user_arbiter: RTL and testbench

- Shared, pipelined ALU server for N_USERS independent user channels; replaces one-ALU-per-user instantiation.
- Each channel issues valid/ready requests (A, B, ALUop); a round-robin arbiter grants one request per cycle to a 2-stage ALU pipeline.
- Each result returns on that channel's own valid/ready response port.
- Sits between the PS-side GPIO/AXI bridge and user logic in the static top level.

---
 rtl/alu_user_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_alu_user_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_user_arbiter.sv
// Shared two-stage ALU serving N_USERS valid/ready request channels.
// A round-robin arbiter feeds one op per cycle; results land in per-channel response buffers.
module alu_user_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int N_USERS    = 4,
  localparam int UW        = (N_USERS > 1) ? $clog2(N_USERS) : 1
) (
  input  logic                          ps_fclk_clk0,
  input  logic                          ps_user_reset_n,
  input  logic [N_USERS-1:0]            user_enable,
  input  logic [N_USERS-1:0]            req_valid,
  output logic [N_USERS-1:0]            req_ready,
  input  logic [N_USERS*DATA_WIDTH-1:0] req_A,
  input  logic [N_USERS*DATA_WIDTH-1:0] req_B,
  input  logic [N_USERS*3-1:0]          req_ALUop,
  output logic [N_USERS-1:0]            rsp_valid,
  input  logic [N_USERS-1:0]            rsp_ready,
  output logic [N_USERS*DATA_WIDTH-1:0] rsp_Result,
  output logic [N_USERS-1:0]            rsp_Overflow,
  output logic [N_USERS-1:0]            rsp_CarryOut,
  output logic [N_USERS-1:0]            rsp_Zero,
  output logic [UW-1:0]                 grant_id
);

  localparam int unsigned NU = N_USERS;
  localparam int unsigned DW = DATA_WIDTH;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b110,
    OP_SLT = 3'b111
  } alu_op_e;

  logic [UW-1:0]            last_q, last_d;
  logic                     s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0]    s1_a_q, s1_a_d;
  logic [DATA_WIDTH-1:0]    s1_b_q, s1_b_d;
  logic [2:0]               s1_op_q, s1_op_d;
  logic [UW-1:0]            s1_id_q, s1_id_d;
  logic [N_USERS-1:0]       rsp_valid_q, rsp_valid_d;
  logic [N_USERS*DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic [N_USERS-1:0]       rsp_ovf_q, rsp_ovf_d;
  logic [N_USERS-1:0]       rsp_cout_q, rsp_cout_d;
  logic [N_USERS-1:0]       rsp_zero_q, rsp_zero_d;

  logic [N_USERS-1:0]       elig;
  logic                     found;
  int unsigned              idx;
  logic [UW-1:0]            idx_w;
  logic [DATA_WIDTH-1:0]    sel_a, sel_b;
  logic [2:0]               sel_op;

  logic [DATA_WIDTH:0]      add_w;
  logic [DATA_WIDTH-1:0]    sub_w;
  logic [DATA_WIDTH-1:0]    alu_res;
  logic                     alu_c, alu_v, alu_z;

  // A channel is blocked while its op is in stage 1 or its response is still unread.
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NU; i++) begin
      elig[i] = req_valid[i] & user_enable[i] & ~rsp_valid_q[i]
              & ~(s1_valid_q && (s1_id_q == UW'(i)));
    end
  end

  always_comb begin
    req_ready = '0;
    grant_id  = '0;
    found     = 1'b0;
    idx       = 0;
    idx_w     = '0;
    sel_a     = '0;
    sel_b     = '0;
    sel_op    = '0;
    for (int unsigned k = 0; k < NU; k++) begin
      idx   = (32'(last_q) + 1 + k) % NU;
      idx_w = UW'(idx);
      if (!found && elig[idx_w]) begin
        found            = 1'b1;
        req_ready[idx_w] = 1'b1;
        grant_id         = idx_w;
        sel_a            = req_A[idx*DW +: DATA_WIDTH];
        sel_b            = req_B[idx*DW +: DATA_WIDTH];
        sel_op           = req_ALUop[idx*3 +: 3];
      end
    end
  end

  always_comb begin
    last_d     = last_q;
    s1_valid_d = found;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    s1_id_d    = s1_id_q;
    if (found) begin
      last_d  = grant_id;
      s1_a_d  = sel_a;
      s1_b_d  = sel_b;
      s1_op_d = sel_op;
      s1_id_d = grant_id;
    end
  end

  always_comb begin
    add_w   = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    sub_w   = s1_a_q - s1_b_q;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (s1_op_q)
      OP_AND: alu_res = s1_a_q & s1_b_q;
      OP_OR:  alu_res = s1_a_q | s1_b_q;
      OP_ADD: begin
        alu_res = add_w[DATA_WIDTH-1:0];
        alu_c   = add_w[DATA_WIDTH];
        alu_v   = (s1_a_q[DATA_WIDTH-1] == s1_b_q[DATA_WIDTH-1])
               && (add_w[DATA_WIDTH-1] != s1_a_q[DATA_WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_w;
        alu_c   = (s1_a_q < s1_b_q);
        alu_v   = (s1_a_q[DATA_WIDTH-1] != s1_b_q[DATA_WIDTH-1])
               && (sub_w[DATA_WIDTH-1] != s1_a_q[DATA_WIDTH-1]);
      end
      OP_SLT: alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(s1_a_q) < $signed(s1_b_q))};
      default: alu_res = '0;
    endcase
    alu_z = (alu_res == '0);
  end

  // Stage 2 never targets a channel with an unread response, so set and clear cannot collide.
  always_comb begin
    rsp_valid_d  = rsp_valid_q & ~rsp_ready;
    rsp_result_d = rsp_result_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_cout_d   = rsp_cout_q;
    rsp_zero_d   = rsp_zero_q;
    if (s1_valid_q) begin
      rsp_valid_d[s1_id_q]                       = 1'b1;
      rsp_result_d[32'(s1_id_q)*DW +: DATA_WIDTH] = alu_res;
      rsp_ovf_d[s1_id_q]                         = alu_v;
      rsp_cout_d[s1_id_q]                        = alu_c;
      rsp_zero_d[s1_id_q]                        = alu_z;
    end
  end

  always_ff @(posedge ps_fclk_clk0 or negedge ps_user_reset_n) begin
    if (!ps_user_reset_n) begin
      last_q       <= UW'(N_USERS - 1);
      s1_valid_q   <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_op_q      <= '0;
      s1_id_q      <= '0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_ovf_q    <= '0;
      rsp_cout_q   <= '0;
      rsp_zero_q   <= '0;
    end else begin
      last_q       <= last_d;
      s1_valid_q   <= s1_valid_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s1_op_q      <= s1_op_d;
      s1_id_q      <= s1_id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_cout_q   <= rsp_cout_d;
      rsp_zero_q   <= rsp_zero_d;
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_Result   = rsp_result_q;
  assign rsp_Overflow = rsp_ovf_q;
  assign rsp_CarryOut = rsp_cout_q;
  assign rsp_Zero     = rsp_zero_q;

endmodule

// File: tb/tb_alu_user_arbiter.sv
// Directed bench for alu_user_arbiter: arbitration order, ALU results/flags, backpressure,
// enable masking and reset behaviour, all against hand-computed values.
module tb_alu_user_arbiter;
  localparam int DW = 32;
  localparam int NU = 4;
  localparam logic [2:0] AND_OP = 3'b000, OR_OP = 3'b001, ADD_OP = 3'b010,
                         SUB_OP = 3'b110, SLT_OP = 3'b111, BAD_OP = 3'b011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NU-1:0]    user_enable, req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NU*DW-1:0] req_A, req_B, rsp_Result;
  logic [NU*3-1:0]  req_ALUop;
  logic [NU-1:0]    rsp_Overflow, rsp_CarryOut, rsp_Zero;
  logic [1:0]       grant_id;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_user_arbiter #(.DATA_WIDTH(DW), .N_USERS(NU)) dut (
    .ps_fclk_clk0(clk), .ps_user_reset_n(rst_n), .user_enable(user_enable),
    .req_valid(req_valid), .req_ready(req_ready), .req_A(req_A), .req_B(req_B),
    .req_ALUop(req_ALUop), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_Result(rsp_Result), .rsp_Overflow(rsp_Overflow), .rsp_CarryOut(rsp_CarryOut),
    .rsp_Zero(rsp_Zero), .grant_id(grant_id)
  );

  typedef struct {
    int          ch;
    logic [31:0] a, b;
    logic [2:0]  op;
    logic [31:0] r;
    logic        c, v, z;
  } vec_t;

  task automatic set_req(input int ch, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op);
    req_A[ch*DW +: DW]   = a;
    req_B[ch*DW +: DW]   = b;
    req_ALUop[ch*3 +: 3] = op;
    req_valid[ch]        = 1'b1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    req_valid   = '0;
    req_A       = '0;
    req_B       = '0;
    req_ALUop   = '0;
    user_enable = '1;
    rsp_ready   = '1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Issues one op on an otherwise idle bench and samples the channel's response buffer.
  task automatic run_op(input int ch, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, output bit granted, output logic [1:0] gid,
                        output logic rv, output logic [31:0] res,
                        output logic c, output logic v, output logic z);
    granted = 1'b0;
    gid     = '0;
    @(negedge clk);
    set_req(ch, a, b, op);
    for (int t = 0; t < 8 && !granted; t++) begin
      #1;
      if (req_ready[ch]) begin
        granted = 1'b1;
        gid     = grant_id;
      end else begin
        @(negedge clk);
      end
    end
    @(negedge clk);
    req_valid[ch] = 1'b0;
    @(negedge clk);
    #1;
    rv  = rsp_valid[ch];
    res = rsp_Result[ch*DW +: DW];
    c   = rsp_CarryOut[ch];
    v   = rsp_Overflow[ch];
    z   = rsp_Zero[ch];
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; req_A = '0; req_B = '0; req_ALUop = '0;
    user_enable = '1; rsp_ready = '1;
    @(negedge clk); #1;
    n_cmp++; if (rsp_valid !== 4'b0) begin n_bad++; $display("FAIL reset_rsp_valid got %b want 0000", rsp_valid); end
    n_cmp++; if (rsp_Result !== '0) begin n_bad++; $display("FAIL reset_result got %h want 0", rsp_Result); end
    n_cmp++; if ({rsp_Overflow, rsp_CarryOut, rsp_Zero} !== 12'b0) begin n_bad++;
      $display("FAIL reset_flags got %b want 0", {rsp_Overflow, rsp_CarryOut, rsp_Zero}); end
    rst_n = 1'b1;
    @(negedge clk);
    set_req(0, 32'd5, 32'd7, ADD_OP);
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL first_ready got %b want 0001", req_ready); end
    n_cmp++; if (grant_id !== 2'd0) begin n_bad++; $display("FAIL first_grant got %0d want 0", grant_id); end
    @(negedge clk);
    req_valid[0] = 1'b0;
    #1;
    n_cmp++; if (rsp_valid !== 4'b0) begin n_bad++; $display("FAIL first_rsp_early got %b want 0000", rsp_valid); end
    @(negedge clk); #1;
    n_cmp++; if (rsp_valid !== 4'b0001) begin n_bad++; $display("FAIL first_rsp_valid got %b want 0001", rsp_valid); end
    n_cmp++; if ({rsp_Result[31:0], rsp_Zero[0], rsp_CarryOut[0], rsp_Overflow[0]} !== {32'd12, 3'b000}) begin n_bad++;
      $display("FAIL first_rsp_data got %h z%b c%b v%b want 0000000c z0 c0 v0",
               rsp_Result[31:0], rsp_Zero[0], rsp_CarryOut[0], rsp_Overflow[0]); end
    @(negedge clk); #1;
    n_cmp++; if (rsp_valid !== 4'b0) begin n_bad++; $display("FAIL first_rsp_clear got %b want 0000", rsp_valid); end
  endtask

  task automatic test_contention();
    logic [31:0] exp_r [4];
    logic [3:0]  exp_ready, exp_rv;
    exp_r[0] = 32'h0000F000; exp_r[1] = 32'h000000FF; exp_r[2] = 32'd123; exp_r[3] = 32'd6;
    do_reset();
    @(negedge clk);
    set_req(0, 32'h0000F0F0, 32'h0000FF00, AND_OP);
    set_req(1, 32'h0000000F, 32'h000000F0, OR_OP);
    set_req(2, 32'd100, 32'd23, ADD_OP);
    set_req(3, 32'd10, 32'd4, SUB_OP);
    for (int k = 0; k < 6; k++) begin
      #1;
      exp_ready = (k < 4) ? 4'(1 << k) : 4'b0;
      exp_rv    = (k >= 2) ? 4'(1 << (k - 2)) : 4'b0;
      n_cmp++; if (req_ready !== exp_ready) begin n_bad++;
        $display("FAIL cont_ready cyc%0d got %b want %b", k, req_ready, exp_ready); end
      if (k < 4) begin
        n_cmp++; if (grant_id !== 2'(k)) begin n_bad++;
          $display("FAIL cont_grant cyc%0d got %0d want %0d", k, grant_id, k); end
      end
      n_cmp++; if (rsp_valid !== exp_rv) begin n_bad++;
        $display("FAIL cont_rsp_valid cyc%0d got %b want %b", k, rsp_valid, exp_rv); end
      if (k >= 2) begin
        n_cmp++; if (rsp_Result[(k-2)*DW +: DW] !== exp_r[k-2]) begin n_bad++;
          $display("FAIL cont_result ch%0d got %h want %h", k - 2, rsp_Result[(k-2)*DW +: DW], exp_r[k-2]); end
      end
      @(negedge clk);
      if (k < 4) req_valid[k] = 1'b0;
    end
  endtask

  task automatic test_rotation();
    do_reset();
    @(negedge clk);
    for (int ch = 0; ch < NU; ch++) set_req(ch, 32'(ch + 1), 32'(ch), ADD_OP);
    for (int k = 0; k < 10; k++) begin
      #1;
      n_cmp++; if (req_ready !== 4'(1 << (k % 4)) || grant_id !== 2'(k % 4)) begin n_bad++;
        $display("FAIL rotation cyc%0d got ready %b grant %0d want grant %0d", k, req_ready, grant_id, k % 4); end
      @(negedge clk);
    end
    req_valid = '0;
  endtask

  task automatic test_alu_ops();
    vec_t tbl [10];
    bit granted; logic [1:0] gid; logic rv, c, v, z; logic [31:0] res;
    tbl[0] = '{2, 32'h7FFFFFFF, 32'h00000001, ADD_OP, 32'h80000000, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{2, 32'hFFFFFFFF, 32'h00000001, ADD_OP, 32'h00000000, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{1, 32'h00000003, 32'h00000005, SUB_OP, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1, 32'hFFFFFFFF, 32'h00000001, SLT_OP, 32'h00000001, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1, 32'h80000000, 32'h00000001, SUB_OP, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{0, 32'hF0F0F0F0, 32'h0F0F0F0F, AND_OP, 32'h00000000, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{0, 32'h12340000, 32'h00005678, OR_OP,  32'h12345678, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{3, 32'h00000005, 32'h00000006, BAD_OP, 32'h00000000, 1'b0, 1'b0, 1'b1};
    tbl[8] = '{3, 32'h00000001, 32'hFFFFFFFF, SLT_OP, 32'h00000000, 1'b0, 1'b0, 1'b1};
    tbl[9] = '{3, 32'h00000005, 32'h00000005, SUB_OP, 32'h00000000, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].ch, tbl[i].a, tbl[i].b, tbl[i].op, granted, gid, rv, res, c, v, z);
      n_cmp++; if (!granted || gid !== 2'(tbl[i].ch)) begin n_bad++;
        $display("FAIL alu_grant vec%0d got granted=%0d id=%0d want id=%0d", i, granted, gid, tbl[i].ch); end
      n_cmp++; if ({rv, res, c, v, z} !== {1'b1, tbl[i].r, tbl[i].c, tbl[i].v, tbl[i].z}) begin n_bad++;
        $display("FAIL alu_result vec%0d got vld%b %h c%b v%b z%b want vld1 %h c%b v%b z%b",
                 i, rv, res, c, v, z, tbl[i].r, tbl[i].c, tbl[i].v, tbl[i].z); end
    end
  endtask

  task automatic test_backpressure();
    bit granted; logic [1:0] gid; logic rv, c, v, z; logic [31:0] res;
    do_reset();
    rsp_ready[3] = 1'b0;
    run_op(3, 32'd1, 32'd1, ADD_OP, granted, gid, rv, res, c, v, z);
    n_cmp++; if (!granted || rv !== 1'b1 || res !== 32'd2) begin n_bad++;
      $display("FAIL bp_first got granted=%0d vld%b %h want 1 1 00000002", granted, rv, res); end
    @(negedge clk);
    set_req(3, 32'd10, 32'd20, ADD_OP);
    set_req(0, 32'd7, 32'd8, ADD_OP);
    #1;
    n_cmp++; if (req_ready !== 4'b0001 || rsp_valid !== 4'b1000) begin n_bad++;
      $display("FAIL bp_other_served got ready %b rsp %b want 0001 1000", req_ready, rsp_valid); end
    @(negedge clk);
    req_valid[0] = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL bp_blocked got %b want 0000", req_ready); end
    @(negedge clk); #1;
    n_cmp++; if (rsp_valid !== 4'b1001 || rsp_Result[31:0] !== 32'd15 || rsp_Result[3*DW +: DW] !== 32'd2) begin n_bad++;
      $display("FAIL bp_rsp got %b %h %h want 1001 0000000f 00000002", rsp_valid, rsp_Result[31:0], rsp_Result[3*DW +: DW]); end
    rsp_ready[3] = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL bp_still_blocked got %b want 0000", req_ready); end
    @(negedge clk); #1;
    n_cmp++; if (rsp_valid !== 4'b0000 || req_ready !== 4'b1000 || grant_id !== 2'd3) begin n_bad++;
      $display("FAIL bp_release got rsp %b ready %b id %0d want 0000 1000 3", rsp_valid, req_ready, grant_id); end
    @(negedge clk);
    req_valid[3] = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (rsp_valid !== 4'b1000 || rsp_Result[3*DW +: DW] !== 32'd30) begin n_bad++;
      $display("FAIL bp_second got %b %h want 1000 0000001e", rsp_valid, rsp_Result[3*DW +: DW]); end
  endtask

  task automatic test_enable_reset();
    bit granted; logic [1:0] gid; logic rv, c, v, z; logic [31:0] res;
    do_reset();
    @(negedge clk);
    set_req(1, 32'd2, 32'd2, ADD_OP);
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL en_accept got %b want 0010", req_ready); end
    @(negedge clk);
    user_enable[1] = 1'b0;
    set_req(1, 32'd8, 32'd8, ADD_OP);
    #1;
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL en_masked1 got %b want 0000", req_ready); end
    @(negedge clk); #1;
    n_cmp++; if (rsp_valid !== 4'b0010 || rsp_Result[DW +: DW] !== 32'd4 || req_ready !== 4'b0000) begin n_bad++;
      $display("FAIL en_inflight got rsp %b %h ready %b want 0010 00000004 0000",
               rsp_valid, rsp_Result[DW +: DW], req_ready); end
    @(negedge clk); #1;
    n_cmp++; if (req_ready !== 4'b0000 || rsp_valid !== 4'b0000) begin n_bad++;
      $display("FAIL en_masked2 got ready %b rsp %b want 0000 0000", req_ready, rsp_valid); end
    req_valid[1] = 1'b0;
    user_enable = '1;
    rsp_ready[0] = 1'b0;
    run_op(0, 32'd1, 32'd2, ADD_OP, granted, gid, rv, res, c, v, z);
    n_cmp++; if (!granted || rv !== 1'b1 || res !== 32'd3) begin n_bad++;
      $display("FAIL rst_pending got granted=%0d vld%b %h want 1 1 00000003", granted, rv, res); end
    @(negedge clk);
    set_req(2, 32'd3, 32'd3, ADD_OP);
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL rst_accept got %b want 0100", req_ready); end
    @(negedge clk);
    req_valid[2] = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (rsp_valid !== 4'b0000 || rsp_Result !== '0) begin n_bad++;
      $display("FAIL rst_immediate got rsp %b result %h want 0000 0", rsp_valid, rsp_Result); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      n_cmp++; if (rsp_valid !== 4'b0000) begin n_bad++;
        $display("FAIL rst_stale cyc%0d got %b want 0000", k, rsp_valid); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_contention();
    test_rotation();
    test_alu_ops();
    test_backpressure();
    test_enable_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
